ssd_scan_decoder: RTL
=====================

# ssd_scan_decoder

Receive-side monitor for the multiplexed seven-segment bus: samples the active-low anode strobes and segment lines, qualifies each scanned pattern as stable, and decodes it back into the 4-bit display code used by the display encoder (0–9, dash, blank). It sits on the board-level display pins, or on a testbench/loopback tap of them, so ALU results driven to the display can be read back as binary digits for self-check and readback logic.

## Interface
- NUM_DIGITS, 4, number of anode lines and digit slots (2..8)
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (2..255)

- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- an  input  NUM_DIGITS  anode strobes, active-low, one-hot-low when a digit is driven
- seg  input  7  segment lines, active-low, bit 6 = a … bit 0 = g
- digits  output  4*NUM_DIGITS  decoded code per digit; digit i at [4i+3:4i]
- digit_valid  output  NUM_DIGITS  digit i has been committed at least once since reset
- commit  output  1  one-cycle pulse: a digit slot was written this cycle
- frame_done  output  1  one-cycle pulse: every digit slot committed since last frame_done
- err  output  1  one-cycle pulse: illegal anode or segment pattern qualified

## Operation
- Decode map (seg → code): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 1111110→A (dash), 1111111→B (blank); any other pattern → F plus err.
- Inputs registered once (r_an, r_seg). Stability counter cnt (8 bit): incoming {an,seg} equal to {r_an,r_seg} → cnt increments (saturating); unequal → cnt = 0, sample reloads.
- FSM states: IDLE, QUALIFY, COMMIT, HOLD.
  - IDLE: r_an all ones (blanking gap) → stay. Otherwise → QUALIFY.
  - QUALIFY: sample changes → back to IDLE/QUALIFY per new sample. cnt == STABLE_CYCLES-1 → COMMIT.
  - COMMIT (one cycle): r_an one-hot-low → write digits[idx], set digit_valid[idx] and seen[idx], pulse commit; if seg illegal, write F and pulse err. r_an has more than one low bit → no write, pulse err. → HOLD.
  - HOLD: no further commits until sample changes; then → IDLE.
- seen mask: on the commit that makes seen all ones, pulse frame_done in the same cycle and clear seen. A digit recommitted before frame completes just overwrites its slot.
- Reset mid-qualification abandons the pattern; no partial commit.

## Timing
- Reset values: digits all 0, digit_valid 0, seen 0, commit/frame_done/err 0, state IDLE, cnt 0.
- Latency: a pattern first present at the pin on edge k is committed (commit high, digits updated) at edge k+STABLE_CYCLES+1.
- Glitches shorter than STABLE_CYCLES cycles are never committed.
- commit, frame_done and err may assert in the same cycle; each lasts exactly one cycle.
- One commit per stable pattern, regardless of dwell time.

## Configuration
- SSD_DEC_ERR_COUNT_EN defined: adds output err_count [7:0], incremented on each err pulse, saturating at 255, reset to 0.
- Undefined: port absent, no counter logic; all other behaviour identical.

## Structure
- Package ssd_pkg: segment-pattern constants for 0–9, dash and blank; code constants CODE_DASH = 4'hA, CODE_BLANK = 4'hB, CODE_BAD = 4'hF; FSM state enum. Shared with the display encoder so both ends use one table.
- One sub-module: ssd_seg_to_code (combinational seg → {code, illegal}); FSM, counter and digit registers stay in the top.

## Test plan
- Reset then hold an=1110, seg=0010010 for 10 cycles → one commit at cycle STABLE_CYCLES+1, digits[3:0]=2, digit_valid=0001, no err.
- Scan 4 digits (an 1110/1101/1011/0111, seg for 1,2,3,4), 8 cycles each → four commits, digits=16'h4321, frame_done on fourth commit only.
- Pattern held 2 cycles (< STABLE_CYCLES) between valid digits → no commit, digits unchanged.
- an=1100 stable 8 cycles → err pulse, no digits write; seg=1010101 on an=1110 → digits[3:0]=F, err and commit pulse.
- Dash and blank: seg=1111110 → code A; seg=1111111 → code B, both commit without err.
- reset asserted mid-QUALIFY → all outputs zero immediately; no commit after release until a new full qualification.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared seven-segment pattern table, display codes and decoder FSM states
package ssd_pkg;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_QUALIFY = 2'd1;
  localparam state_t ST_COMMIT  = 2'd2;
  localparam state_t ST_HOLD    = 2'd3;

endpackage

// File: rtl/ssd_seg_to_code.sv
// rtl/ssd_seg_to_code.sv - combinational segment pattern to display code lookup
module ssd_seg_to_code
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       illegal
);

  always_comb begin
    illegal = 1'b0;
    case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_DASH:  code = CODE_DASH;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code    = CODE_BAD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// rtl/ssd_scan_decoder.sv - qualifies scanned anode/segment patterns and decodes them per digit slot
// Optional SSD_DEC_ERR_COUNT_EN adds a saturating err_count output.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    commit,
  output logic                    frame_done,
  output logic                    err
`ifdef SSD_DEC_ERR_COUNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic [7:0]            cnt;
  state_t                state, next_state;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] hit;
  logic                  changed;
  logic                  one_hot;
  logic [3:0]            dec_code;
  logic                  dec_illegal;

  assign changed = ({an, seg} != {r_an, r_seg});
  assign hit     = ~r_an;
  assign one_hot = $onehot(hit);

  ssd_seg_to_code u_seg_to_code (
    .seg     (r_seg),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // Reset sample is the blanking pattern so the first real pattern always reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= '1;
      r_seg <= '1;
      cnt   <= '0;
    end else if (changed) begin
      r_an  <= an;
      r_seg <= seg;
      cnt   <= '0;
    end else if (cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (!(&r_an)) next_state = ST_QUALIFY;
      ST_QUALIFY: begin
        if (changed)              next_state = ST_IDLE;
        else if (cnt == CNT_LAST) next_state = ST_COMMIT;
      end
      // A change arriving during the commit cycle must not be swallowed by HOLD.
      ST_COMMIT:  next_state = changed ? ST_IDLE : ST_HOLD;
      ST_HOLD:    if (changed) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits      <= '0;
      digit_valid <= '0;
      seen        <= '0;
      commit      <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      commit     <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (state == ST_COMMIT) begin
        if (one_hot) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (hit[i]) digits[4*i +: 4] <= dec_code;
          end
          digit_valid <= digit_valid | hit;
          commit      <= 1'b1;
          err         <= dec_illegal;
          if (&(seen | hit)) begin
            frame_done <= 1'b1;
            seen       <= '0;
          end else begin
            seen <= seen | hit;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

`ifdef SSD_DEC_ERR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_count <= '0;
    else if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
